// File: rtl/alu_txn_driver.sv
// -----------------------------------------------------------------------------
// alu_txn_driver
//
// Initiator-side driver for the ALU operand interface. Accepts one operation at
// a time on a valid/ready request port, drives CE/MODE/CMD/INP_VALID/OPA/OPB/CIN
// following the ALU's operand-validity rules, captures RES and the flags after
// the configured latency, and returns them on a valid/ready response port.
//
// Optional feature macro:
//   ALU_DRV_SPLIT_EN - compiles in split operand delivery: an A-only phase
//                      (INP_VALID=01) followed by req_gap idle cycles before
//                      the full-operand phase. Undefined: req_split/req_gap
//                      are ignored and every legal op is issued in one cycle.
//
// Parameters:
//   WIDTH      operand width (RES is WIDTH+1)
//   CMD_WIDTH  command width
//   RES_LAT    cycles from the last drive cycle to RES valid (>= 1)
//
// Ports:
//   clk, rst                 rising-edge clock, async active-low reset
//   req_valid / req_ready    request handshake
//   req_mode, req_cin        MODE and CIN for the operation
//   req_split, req_gap       split delivery request and A-to-full idle cycles
//   req_cmd, req_opa/opb     command and operands
//   CE, MODE, CIN, CMD       ALU control outputs (registered)
//   INP_VALID, OPA, OPB      ALU operand outputs (registered)
//   RES, ERR..E              ALU result and flags
//   rsp_valid / rsp_ready    response handshake
//   rsp_res, rsp_flags       captured RES and {ERR,OFLOW,COUT,G,L,E}
//   rsp_illegal              command rejected, ALU never driven
// -----------------------------------------------------------------------------
module alu_txn_driver #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int RES_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_mode,
  input  logic                 req_cin,
  input  logic                 req_split,
  input  logic [CMD_WIDTH-1:0] req_cmd,
  input  logic [WIDTH-1:0]     req_opa,
  input  logic [WIDTH-1:0]     req_opb,
  input  logic [3:0]           req_gap,
  output logic                 CE,
  output logic                 MODE,
  output logic                 CIN,
  output logic [CMD_WIDTH-1:0] CMD,
  output logic [1:0]           INP_VALID,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  input  logic [WIDTH:0]       RES,
  input  logic                 ERR,
  input  logic                 OFLOW,
  input  logic                 COUT,
  input  logic                 G,
  input  logic                 L,
  input  logic                 E,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH:0]       rsp_res,
  output logic [5:0]           rsp_flags,
  output logic                 rsp_illegal
);

  // Wide enough to hold RES_LAT, the longest wait countdown start value.
  localparam int LAT_W = $clog2(RES_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRV_A,
    S_GAP,
    S_DRV,
    S_WAIT,
    S_RESP
  } state_e;

  // Required INP_VALID code for a command; 2'b00 marks an illegal command.
  // Bit 0 = OPA valid, bit 1 = OPB valid.
  function automatic logic [1:0] req_code(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    logic [31:0] c;
    c = 32'(cmd);
    req_code = 2'b00;
    if (mode) begin
      if (c <= 3 || (c >= 8 && c <= 10)) req_code = 2'b11;
      else if (c == 4 || c == 5)         req_code = 2'b01;
      else if (c == 6 || c == 7)         req_code = 2'b10;
    end else begin
      if (c <= 5 || c == 12 || c == 13)     req_code = 2'b11;
      else if (c == 6 || c == 8 || c == 9)  req_code = 2'b01;
      else if (c == 7 || c == 10 || c == 11) req_code = 2'b10;
    end
  endfunction

  // Arithmetic-mode CMD 9 and 10 take one extra result cycle in the ALU.
  function automatic logic long_lat(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    long_lat = mode && (32'(cmd) == 9 || 32'(cmd) == 10);
  endfunction

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic                   cin_q, cin_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic [WIDTH-1:0]       opa_q, opa_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [1:0]             code_q, code_d;
  logic [LAT_W-1:0]       wait_cnt_q, wait_cnt_d;
`ifdef ALU_DRV_SPLIT_EN
  logic [3:0]             gap_q, gap_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;
`else
  logic                   unused_split;
  assign unused_split = ^{req_split, req_gap};
`endif

  // Output registers
  logic                   ready_q, ready_d;
  logic                   ce_q, ce_d;
  logic                   alu_mode_q, alu_mode_d;
  logic                   alu_cin_q, alu_cin_d;
  logic [CMD_WIDTH-1:0]   alu_cmd_q, alu_cmd_d;
  logic [1:0]             inp_valid_q, inp_valid_d;
  logic [WIDTH-1:0]       alu_opa_q, alu_opa_d;
  logic [WIDTH-1:0]       alu_opb_q, alu_opb_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]         rsp_res_q, rsp_res_d;
  logic [5:0]             rsp_flags_q, rsp_flags_d;
  logic                   rsp_illegal_q, rsp_illegal_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    cin_d      = cin_q;
    cmd_d      = cmd_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    code_d     = code_q;
    wait_cnt_d = wait_cnt_q;
`ifdef ALU_DRV_SPLIT_EN
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // ready_q gates acceptance so nothing is taken in the cycle after reset release.
        if (req_valid && ready_q) begin
          mode_d = req_mode;
          cin_d  = req_cin;
          cmd_d  = req_cmd;
          opa_d  = req_opa;
          opb_d  = req_opb;
          code_d = req_code(req_mode, req_cmd);
          if (code_d == 2'b00) begin
            state_d = S_RESP;
          end else begin
            state_d = S_DRV;
`ifdef ALU_DRV_SPLIT_EN
            gap_d = req_gap;
            // Only two-operand commands can be delivered in two phases.
            if (req_split && code_d == 2'b11) state_d = S_DRV_A;
`endif
          end
        end
      end
`ifdef ALU_DRV_SPLIT_EN
      S_DRV_A: begin
        if (gap_q == 4'd0) begin
          state_d = S_DRV;
        end else begin
          gap_cnt_d = gap_q - 4'd1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = S_DRV;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
`endif
      S_DRV: begin
        // Countdown start is (latency - 1): the last WAIT cycle is the capture edge.
        wait_cnt_d = long_lat(mode_q, cmd_q) ? LAT_W'(RES_LAT) : LAT_W'(RES_LAT - 1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) state_d = S_RESP;
        else                  wait_cnt_d = wait_cnt_q - LAT_W'(1);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so every pin
    // changes only on a clock edge and matches the state it belongs to.
    ready_d       = (state_d == S_IDLE);
    ce_d          = 1'b0;
    alu_mode_d    = 1'b0;
    alu_cin_d     = 1'b0;
    alu_cmd_d     = '0;
    inp_valid_d   = 2'b00;
    alu_opa_d     = '0;
    alu_opb_d     = '0;
    rsp_valid_d   = (state_d == S_RESP);
    rsp_res_d     = '0;
    rsp_flags_d   = '0;
    rsp_illegal_d = 1'b0;

    unique case (state_d)
`ifdef ALU_DRV_SPLIT_EN
      S_DRV_A: begin
        ce_d        = 1'b1;
        alu_mode_d  = mode_d;
        alu_cin_d   = cin_d;
        alu_cmd_d   = cmd_d;
        inp_valid_d = 2'b01;
        alu_opa_d   = opa_d;
      end
      S_GAP: begin
        ce_d       = 1'b1;
        alu_mode_d = mode_d;
        alu_cin_d  = cin_d;
        alu_cmd_d  = cmd_d;
      end
`endif
      S_DRV: begin
        ce_d        = 1'b1;
        alu_mode_d  = mode_d;
        alu_cin_d   = cin_d;
        alu_cmd_d   = cmd_d;
        inp_valid_d = code_d;
        alu_opa_d   = code_d[0] ? opa_d : '0;
        alu_opb_d   = code_d[1] ? opb_d : '0;
      end
      S_WAIT: begin
        ce_d       = 1'b1;
        alu_mode_d = mode_d;
        alu_cin_d  = cin_d;
        alu_cmd_d  = cmd_d;
      end
      S_RESP: begin
        if (state_q == S_RESP) begin
          rsp_res_d     = rsp_res_q;
          rsp_flags_d   = rsp_flags_q;
          rsp_illegal_d = rsp_illegal_q;
        end else if (state_q == S_WAIT) begin
          rsp_res_d   = RES;
          rsp_flags_d = {ERR, OFLOW, COUT, G, L, E};
        end else begin
          rsp_illegal_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      cin_q         <= 1'b0;
      cmd_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      code_q        <= 2'b00;
      wait_cnt_q    <= '0;
`ifdef ALU_DRV_SPLIT_EN
      gap_q         <= 4'd0;
      gap_cnt_q     <= 4'd0;
`endif
      ready_q       <= 1'b0;
      ce_q          <= 1'b0;
      alu_mode_q    <= 1'b0;
      alu_cin_q     <= 1'b0;
      alu_cmd_q     <= '0;
      inp_valid_q   <= 2'b00;
      alu_opa_q     <= '0;
      alu_opb_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_res_q     <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      mode_q        <= mode_d;
      cin_q         <= cin_d;
      cmd_q         <= cmd_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      code_q        <= code_d;
      wait_cnt_q    <= wait_cnt_d;
`ifdef ALU_DRV_SPLIT_EN
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
`endif
      ready_q       <= ready_d;
      ce_q          <= ce_d;
      alu_mode_q    <= alu_mode_d;
      alu_cin_q     <= alu_cin_d;
      alu_cmd_q     <= alu_cmd_d;
      inp_valid_q   <= inp_valid_d;
      alu_opa_q     <= alu_opa_d;
      alu_opb_q     <= alu_opb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_res_q     <= rsp_res_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign req_ready   = ready_q;
  assign CE          = ce_q;
  assign MODE        = alu_mode_q;
  assign CIN         = alu_cin_q;
  assign CMD         = alu_cmd_q;
  assign INP_VALID   = inp_valid_q;
  assign OPA         = alu_opa_q;
  assign OPB         = alu_opb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_res     = rsp_res_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_txn_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_txn_driver
//
// Self-checking bench for alu_txn_driver. A small ALU model answers driven
// operations exactly RES_LAT (or RES_LAT+1) cycles after a drive cycle and
// presents inverted data in every other cycle, so a capture on the wrong edge
// shows up as a wrong response. Expected responses go into a scoreboard queue
// when a request is issued and are popped when the response appears.
// -----------------------------------------------------------------------------
module tb_alu_txn_driver;

  localparam int RES_LAT = 1;
`ifdef ALU_DRV_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       illegal;
    logic [8:0] res;
    logic [5:0] flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic       req_mode, req_cin, req_split;
  logic [3:0] req_cmd;
  logic [7:0] req_opa, req_opb;
  logic [3:0] req_gap;
  logic       CE, MODE, CIN;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [7:0] OPA, OPB;
  logic [8:0] RES;
  logic       ERR, OFLOW, COUT, G, L, E;
  logic       rsp_valid, rsp_ready;
  logic [8:0] rsp_res;
  logic [5:0] rsp_flags;
  logic       rsp_illegal;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_txn_driver #(.WIDTH(8), .CMD_WIDTH(4), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_cin(req_cin), .req_split(req_split),
    .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb), .req_gap(req_gap),
    .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB),
    .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .G(G), .L(L), .E(E),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal)
  );

  logic [24:0] alu_pins;
  logic [42:0] all_out;
  assign alu_pins = {CE, MODE, CIN, CMD, INP_VALID, OPA, OPB};
  assign all_out  = {req_ready, alu_pins, rsp_valid, rsp_res, rsp_flags, rsp_illegal};

  // Returns {ERR,OFLOW,COUT,G,L,E,RES} for the operands the ALU sees.
  function automatic logic [14:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'b0, c};
    return {2'b00, s[8], a > b, a < b, a == b, s};
  endfunction

  function automatic logic [1:0] tb_code(input logic mode, input logic [3:0] cmd);
    if (mode) begin
      case (cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10: return 2'b11;
        4'd4, 4'd5:                                 return 2'b01;
        4'd6, 4'd7:                                 return 2'b10;
        default:                                    return 2'b00;
      endcase
    end else begin
      case (cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: return 2'b11;
        4'd6, 4'd8, 4'd9:                                  return 2'b01;
        4'd7, 4'd10, 4'd11:                                return 2'b10;
        default:                                           return 2'b00;
      endcase
    end
  endfunction

  // ALU model: result due RES_LAT cycles after a drive cycle (one more for
  // MODE=1 CMD 9/10); inverted data is shown in every other cycle.
  int          cyc = 0;
  int          due = -1;
  logic [14:0] m_out = '0;
  logic [14:0] alu_drv;
  assign {ERR, OFLOW, COUT, G, L, E, RES} = alu_drv;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (CE && INP_VALID != 2'b00) begin
      due   <= cyc + ((MODE && (CMD == 4'd9 || CMD == 4'd10)) ? RES_LAT + 1 : RES_LAT);
      m_out <= alu_fn(OPA, OPB, CIN);
    end
  end

  always @(negedge clk) begin
    if (cyc == due) alu_drv <= m_out;
    else            alu_drv <= ~m_out;
  end

  // Presents one request and returns at the negedge of cycle 1 after acceptance.
  task automatic issue(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic split,
                       input logic [3:0] gap);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_mode = mode; req_cmd = cmd; req_opa = a; req_opb = b;
    req_cin = cin; req_split = split; req_gap = gap;
    @(negedge clk);
    req_valid = 1'b0; req_opa = ~a; req_opb = ~b; req_cin = ~cin; req_cmd = ~cmd;
  endtask

  task automatic txn(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                     input logic [7:0] b, input logic cin, input logic split,
                     input logic [3:0] gap, input int hold, input string name);
    logic [1:0]  code;
    logic [7:0]  au, bu;
    logic [14:0] r;
    int          lat, drv_off, rsp_off, rel;
    bit          do_split;
    exp_t        e, got;
    code     = tb_code(mode, cmd);
    au       = code[0] ? a : 8'h00;
    bu       = code[1] ? b : 8'h00;
    lat      = (mode && (cmd == 4'd9 || cmd == 4'd10)) ? RES_LAT + 1 : RES_LAT;
    do_split = SPLIT_EN && split && (code == 2'b11);
    drv_off  = do_split ? 2 + int'(gap) : 1;
    rsp_off  = (code == 2'b00) ? 1 : drv_off + lat + 1;
    if (code == 2'b00) begin
      e = '{illegal: 1'b1, res: 9'h000, flags: 6'h00};
    end else begin
      r = alu_fn(au, bu, cin);
      e = '{illegal: 1'b0, res: r[8:0], flags: r[14:9]};
    end
    sb_q.push_back(e);

    issue(mode, cmd, a, b, cin, split, gap);
    rel = 1;
    while (rsp_valid !== 1'b1 && rel < rsp_off + 8) begin
      if (do_split && rel == 1) begin
        checks++;
        if ({CE, INP_VALID, OPA, OPB} !== {1'b1, 2'b01, a, 8'h00}) begin
          errors++;
          $display("FAIL %s a_phase: got %h required %h", name, {CE, INP_VALID, OPA, OPB}, {1'b1, 2'b01, a, 8'h00});
        end
      end
      if (do_split && rel > 1 && rel < drv_off) begin
        checks++;
        if ({CE, MODE, CMD, INP_VALID} !== {1'b1, mode, cmd, 2'b00}) begin
          errors++;
          $display("FAIL %s gap_cycle%0d: got %h required %h", name, rel, {CE, MODE, CMD, INP_VALID}, {1'b1, mode, cmd, 2'b00});
        end
      end
      if (rel == drv_off) begin
        checks++;
        if (alu_pins !== {1'b1, mode, cin, cmd, code, au, bu}) begin
          errors++;
          $display("FAIL %s drv_pins: got %h required %h", name, alu_pins, {1'b1, mode, cin, cmd, code, au, bu});
        end
      end
      if (rel == drv_off + 1) begin
        checks++;
        if ({CE, MODE, CIN, CMD, INP_VALID} !== {1'b1, mode, cin, cmd, 2'b00}) begin
          errors++;
          $display("FAIL %s wait_pins: got %h required %h", name, {CE, MODE, CIN, CMD, INP_VALID}, {1'b1, mode, cin, cmd, 2'b00});
        end
      end
      @(negedge clk);
      rel++;
    end

    checks++;
    if (rel != rsp_off || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_latency: rsp_valid=%b at cycle %0d, required 1 at cycle %0d", name, rsp_valid, rel, rsp_off);
    end
    got = sb_q.pop_front();
    checks++;
    if ({rsp_illegal, rsp_res, rsp_flags} !== got) begin
      errors++;
      $display("FAIL %s rsp_data: got %h required %h", name, {rsp_illegal, rsp_res, rsp_flags}, got);
    end
    checks++;
    if (alu_pins !== 25'd0) begin
      errors++;
      $display("FAIL %s resp_alu_idle: got %h required 0", name, alu_pins);
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_illegal, rsp_res, rsp_flags} !== {1'b1, got}) begin
        errors++;
        $display("FAIL %s rsp_stable%0d: got %h required %h", name, i, {rsp_valid, rsp_illegal, rsp_res, rsp_flags}, {1'b1, got});
      end
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s turnaround: rsp_valid,req_ready=%b required 01", name, {rsp_valid, req_ready});
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (all_out !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, CE} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: req_ready,rsp_valid,CE=%b required 100", {req_ready, rsp_valid, CE});
    end
  endtask

  task automatic test_mode1_add;
    txn(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0, 4'd0, 0, "add");
    txn(1'b1, 4'd2, 8'hFF, 8'h01, 1'b1, 1'b0, 4'd0, 0, "add_carry");
  endtask

  task automatic test_single_operand;
    txn(1'b0, 4'd6, 8'hAA, 8'h55, 1'b0, 1'b0, 4'd0, 0, "m0_cmd6");
    txn(1'b0, 4'd7, 8'h3C, 8'h21, 1'b0, 1'b0, 4'd0, 0, "m0_cmd7");
    txn(1'b1, 4'd4, 8'h12, 8'h34, 1'b1, 1'b0, 4'd0, 0, "m1_cmd4");
    txn(1'b1, 4'd7, 8'h40, 8'h41, 1'b0, 1'b0, 4'd0, 0, "m1_cmd7");
  endtask

  task automatic test_long_latency;
    txn(1'b1, 4'd9,  8'h07, 8'h09, 1'b0, 1'b0, 4'd0, 0, "m1_cmd9");
    txn(1'b1, 4'd10, 8'h80, 8'h80, 1'b1, 1'b0, 4'd0, 0, "m1_cmd10");
  endtask

  task automatic test_illegal;
    txn(1'b0, 4'd14, 8'h11, 8'h22, 1'b0, 1'b0, 4'd0, 0, "illegal_m0_14");
    txn(1'b1, 4'd11, 8'h11, 8'h22, 1'b1, 1'b1, 4'd2, 0, "illegal_m1_11");
    txn(1'b0, 4'd15, 8'hFF, 8'hFF, 1'b0, 1'b0, 4'd0, 2, "illegal_m0_15");
  endtask

  task automatic test_split;
    txn(1'b1, 4'd8, 8'h5A, 8'h5A, 1'b0, 1'b1, 4'd15, 0, "split_gap15");
    txn(1'b1, 4'd8, 8'h80, 8'h90, 1'b1, 1'b1, 4'd0,  0, "split_gap0");
    txn(1'b1, 4'd4, 8'h12, 8'h34, 1'b0, 1'b1, 4'd3,  0, "split_single_op");
  endtask

  task automatic test_hold_stable;
    txn(1'b0, 4'd2, 8'hC3, 8'h5A, 1'b1, 1'b0, 4'd0, 5, "hold5");
  endtask

  task automatic test_reset_mid;
    bit saw_rsp = 1'b0;
    issue(1'b1, 4'd9, 8'h33, 8'h11, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    checks++;
    if ({CE, INP_VALID} !== 3'b100) begin
      errors++;
      $display("FAIL mid_in_wait: CE,INP_VALID=%b required 100", {CE, INP_VALID});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (all_out !== 43'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got %h required 0", all_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_ready: req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("FAIL mid_dropped: response seen=1 required 0");
    end
  endtask

  task automatic test_idle_rsp_ready;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, CE} !== 3'b010) begin
      errors++;
      $display("FAIL idle_rsp_ready: rsp_valid,req_ready,CE=%b required 010", {rsp_valid, req_ready, CE});
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
          0, "b2b");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_cin = 1'b0; req_split = 1'b0;
    req_cmd = 4'd0; req_opa = 8'h00; req_opb = 8'h00; req_gap = 4'd0; rsp_ready = 1'b0;
    test_reset();
    test_mode1_add();
    test_single_operand();
    test_long_latency();
    test_illegal();
    test_split();
    test_hold_stable();
    test_reset_mid();
    test_idle_rsp_ready();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
